// File: rtl/sad_min_pkg.sv
// Shared defaults and helpers for the SAD minimum search: parameter defaults,
// a constant clog2 and the index-to-motion-vector offset.
package sad_min_pkg;

  localparam int SAD_W_DEF  = 14;
  localparam int N_ROWS_DEF = 16;
  localparam int N_COLS_DEF = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Candidate index to signed offset; callers truncate to their mv width.
  function automatic int mv_offset(input int index, input int n);
    return index - n / 2;
  endfunction

endpackage

// File: rtl/sad_min_tree.sv
// Pipelined min-reduction over N SAD lanes with one registered level per halving;
// a valid/tag sideband travels alongside so the winner leaves with its beat tags.
module sad_min_tree
  import sad_min_pkg::*;
#(
  parameter int N     = N_ROWS_DEF,
  parameter int SAD_W = SAD_W_DEF,
  parameter int TAG_W = 1,
  parameter int IDX_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [N*SAD_W-1:0] in_sad,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [SAD_W-1:0]   out_sad,
  output logic [IDX_W-1:0]   out_idx,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int LV = IDX_W;

  logic [SAD_W-1:0] leaf_sad     [N];
  logic [SAD_W-1:0] heap_sad     [2:2*N-1];
  logic [IDX_W-1:0] heap_idx     [2:2*N-1];
  logic [SAD_W-1:0] node_sad_reg [1:N-1];
  logic [IDX_W-1:0] node_idx_reg [1:N-1];
  logic [LV-1:0]    vld_reg;
  logic [TAG_W-1:0] tag_reg      [LV];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_leaf
      assign leaf_sad[gi] = in_sad[gi*SAD_W +: SAD_W];
    end
  endgenerate

  // Heap layout: node k reduces children 2k (lower lanes) and 2k+1 (upper lanes);
  // leaves sit at N..2N-1, so the root at 1 settles after LV registered levels.
  always_comb begin
    for (int j = 2; j < N; j++) begin
      heap_sad[j] = node_sad_reg[j];
      heap_idx[j] = node_idx_reg[j];
    end
    for (int r = 0; r < N; r++) begin
      heap_sad[N + r] = leaf_sad[r];
      heap_idx[N + r] = IDX_W'(r);
    end
  end

  always_ff @(posedge clk) begin
    // Strict less-than keeps the lower lane; ties go to the upper lane.
    for (int k = 1; k < N; k++) begin
      if (heap_sad[2*k] < heap_sad[2*k+1]) begin
        node_sad_reg[k] <= heap_sad[2*k];
        node_idx_reg[k] <= heap_idx[2*k];
      end else begin
        node_sad_reg[k] <= heap_sad[2*k+1];
        node_idx_reg[k] <= heap_idx[2*k+1];
      end
    end
    tag_reg[0] <= in_tag;
    for (int i = 1; i < LV; i++) tag_reg[i] <= tag_reg[i-1];
    if (rst || flush) vld_reg <= '0;
    else              vld_reg <= LV'({vld_reg, in_valid});
  end

  assign out_valid = vld_reg[LV-1];
  assign out_sad   = node_sad_reg[1];
  assign out_idx   = node_idx_reg[1];
  assign out_tag   = tag_reg[LV-1];
  assign busy      = |vld_reg;

endmodule

// File: rtl/sad_min_search.sv
// Full-search SAD minimum finder: reduces each column through the compare tree,
// keeps a running minimum across the block and hands out (mv_x, mv_y, min_sad).
module sad_min_search
  import sad_min_pkg::*;
#(
  parameter int SAD_W  = SAD_W_DEF,
  parameter int N_ROWS = N_ROWS_DEF,
  parameter int N_COLS = N_COLS_DEF,
  parameter int MVX_W  = clog2(N_COLS),
  parameter int MVY_W  = clog2(N_ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sad_valid,
  input  logic [N_ROWS*SAD_W-1:0] sad_in,
  input  logic                    abort,
  input  logic                    res_ready,
  output logic                    res_valid,
  output logic [MVX_W-1:0]        res_mv_x,
  output logic [MVY_W-1:0]        res_mv_y,
  output logic [SAD_W-1:0]        res_min_sad,
  output logic                    busy,
  output logic                    overflow
);
  localparam int TAG_W = MVX_W + 1;

  logic [MVX_W-1:0] col_reg;
  logic             accept;
  logic             col_last;
  logic             t_valid, t_busy, t_last, t_fire, take_tree, res_load;
  logic [SAD_W-1:0] t_sad;
  logic [MVY_W-1:0] t_row;
  logic [TAG_W-1:0] t_tag;
  logic [MVX_W-1:0] t_col;

  logic             acc_valid_reg;
  logic [SAD_W-1:0] acc_sad_reg;
  logic [MVY_W-1:0] acc_row_reg;
  logic [MVX_W-1:0] acc_col_reg;
  logic [SAD_W-1:0] best_sad;
  logic [MVY_W-1:0] best_row;
  logic [MVX_W-1:0] best_col;

  logic             res_valid_reg, overflow_reg;
  logic [MVX_W-1:0] res_mv_x_reg;
  logic [MVY_W-1:0] res_mv_y_reg;
  logic [SAD_W-1:0] res_sad_reg;

  // abort wins over a coincident beat, so that beat never enters the tree.
  assign accept   = sad_valid && !abort;
  assign col_last = (col_reg == MVX_W'(N_COLS - 1));

  always_ff @(posedge clk) begin
    if (rst || abort) col_reg <= '0;
    else if (accept)  col_reg <= col_reg + MVX_W'(1);
  end

  sad_min_tree #(
    .N     (N_ROWS),
    .SAD_W (SAD_W),
    .TAG_W (TAG_W),
    .IDX_W (MVY_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (accept),
    .in_sad    (sad_in),
    .in_tag    ({col_reg, col_last}),
    .out_valid (t_valid),
    .out_sad   (t_sad),
    .out_idx   (t_row),
    .out_tag   (t_tag),
    .busy      (t_busy)
  );

  assign t_col  = t_tag[TAG_W-1:1];
  assign t_last = t_tag[0];
  assign t_fire = t_valid && !abort;

  // Column 0 always loads so an all-ones SAD is still a legal minimum.
  assign take_tree = (t_col == '0) || (t_sad < acc_sad_reg);
  assign best_sad  = take_tree ? t_sad : acc_sad_reg;
  assign best_row  = take_tree ? t_row : acc_row_reg;
  assign best_col  = take_tree ? t_col : acc_col_reg;
  assign res_load  = t_fire && t_last;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      acc_valid_reg <= 1'b0;
      acc_sad_reg   <= '0;
      acc_row_reg   <= '0;
      acc_col_reg   <= '0;
    end else if (t_fire) begin
      acc_valid_reg <= !t_last;
      acc_sad_reg   <= best_sad;
      acc_row_reg   <= best_row;
      acc_col_reg   <= best_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_mv_x_reg  <= '0;
      res_mv_y_reg  <= '0;
      res_sad_reg   <= '0;
      overflow_reg  <= 1'b0;
    end else if (res_load) begin
      if (res_valid_reg && !res_ready) begin
        overflow_reg <= 1'b1;
      end else begin
        res_valid_reg <= 1'b1;
        res_mv_x_reg  <= MVX_W'(mv_offset(int'(best_col), N_COLS));
        res_mv_y_reg  <= MVY_W'(mv_offset(int'(best_row), N_ROWS));
        res_sad_reg   <= best_sad;
      end
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg <= 1'b0;
      res_mv_x_reg  <= '0;
      res_mv_y_reg  <= '0;
      res_sad_reg   <= '0;
    end
  end

  assign res_valid   = res_valid_reg;
  assign res_mv_x    = res_mv_x_reg;
  assign res_mv_y    = res_mv_y_reg;
  assign res_min_sad = res_sad_reg;
  assign overflow    = overflow_reg;
  assign busy        = (col_reg != '0) || t_busy || acc_valid_reg;

endmodule

// File: tb/tb_sad_min_search.sv
// Randomised and directed checks of sad_min_search against a block-level
// reference model (plain min search over each received block).
module tb_sad_min_search;
  localparam int SAD_W = 14, NR = 16, NC = 16, L = 4;
  localparam int NR2 = 8, NC2 = 32;

  logic clk = 1'b0;
  logic rst, sad_valid, abort, res_ready;
  logic [NR*SAD_W-1:0] sad_in;
  logic res_valid, busy, overflow;
  logic [3:0] res_mv_x, res_mv_y;
  logic [SAD_W-1:0] res_min_sad;

  logic sad_valid2, abort2, res_ready2, res_valid2, busy2, overflow2;
  logic [NR2*SAD_W-1:0] sad_in2;
  logic [4:0] res_mv_x2;
  logic [2:0] res_mv_y2;
  logic [SAD_W-1:0] res_min_sad2;

  always #5 clk = ~clk;

  sad_min_search #(.SAD_W(SAD_W), .N_ROWS(NR), .N_COLS(NC)) u_dut (
    .clk(clk), .rst(rst), .sad_valid(sad_valid), .sad_in(sad_in), .abort(abort),
    .res_ready(res_ready), .res_valid(res_valid), .res_mv_x(res_mv_x),
    .res_mv_y(res_mv_y), .res_min_sad(res_min_sad), .busy(busy), .overflow(overflow)
  );

  sad_min_search #(.SAD_W(SAD_W), .N_ROWS(NR2), .N_COLS(NC2)) u_dut2 (
    .clk(clk), .rst(rst), .sad_valid(sad_valid2), .sad_in(sad_in2), .abort(abort2),
    .res_ready(res_ready2), .res_valid(res_valid2), .res_mv_x(res_mv_x2),
    .res_mv_y(res_mv_y2), .res_min_sad(res_min_sad2), .busy(busy2), .overflow(overflow2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int mvx; int mvy; int sad; } res_t;
  res_t pend[$];
  res_t m_r;
  int   blk [NC][NR];
  int   cyc = 0, mcol = 0, last_edge = 0;
  bit   last_ok = 0, m_held = 0, m_ovf = 0, m_rst = 0, started = 0;
  int   pulses[$];

  // Smallest SAD; ties prefer the earliest column, then the highest lane in it.
  function automatic res_t block_min(input int due);
    res_t t;
    int bs, bc, br;
    bs = blk[0][0]; bc = 0; br = 0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (blk[c][r] < bs || (blk[c][r] == bs && c == bc)) begin
          bs = blk[c][r]; bc = c; br = r;
        end
    t.due = due; t.mvx = bc - NC/2; t.mvy = br - NR/2; t.sad = bs;
    return t;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    m_rst = rst;
    if (rst) begin
      started = 1; mcol = 0; m_held = 0; m_ovf = 0; last_ok = 0;
      pend.delete();
    end else begin
      bit   arr;
      res_t r;
      arr = 0;
      if (abort) pend.delete();
      else if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front(); arr = 1;
      end
      if (arr) begin
        if (m_held && !res_ready) m_ovf = 1;
        else begin m_held = 1; m_r = r; end
      end else if (m_held && res_ready) m_held = 0;

      if (abort) begin
        mcol = 0; last_ok = 0;
      end else if (sad_valid) begin
        for (int i = 0; i < NR; i++) blk[mcol][i] = int'(sad_in[i*SAD_W +: SAD_W]);
        if (mcol == NC-1) begin
          pend.push_back(block_min(cyc + L));
          last_edge = cyc; last_ok = 1;
        end
        mcol = (mcol + 1) % NC;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      if (m_rst) begin
        chk("rst_valid", res_valid, 0);
        chk("rst_mv_x", res_mv_x, 0);
        chk("rst_mv_y", res_mv_y, 0);
        chk("rst_sad", res_min_sad, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
      end else begin
        chk("res_valid", res_valid, m_held);
        if (m_held) begin
          chk("mv_x", $signed(res_mv_x), m_r.mvx);
          chk("mv_y", $signed(res_mv_y), m_r.mvy);
          chk("min_sad", res_min_sad, m_r.sad);
        end
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, (mcol != 0) || (last_ok && (cyc - last_edge) <= L-1));
        if (res_valid) pulses.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [SAD_W-1:0] stim [NC][NR];

  task automatic fill(input int v);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) stim[c][r] = SAD_W'(v);
  endtask

  task automatic drive(input bit v, input int c, input bit ab);
    sad_valid = v;
    abort = ab;
    for (int r = 0; r < NR; r++)
      sad_in[r*SAD_W +: SAD_W] = v ? stim[c][r] : SAD_W'($urandom);
    @(posedge clk); #1;
    sad_valid = 0;
    abort = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic send_block(input int gap_pct, input int abort_pct, input int rdy_pct);
    for (int c = 0; c < NC; c++) begin
      while ($urandom_range(99) < gap_pct) begin
        res_ready = ($urandom_range(99) < rdy_pct);
        drive(0, 0, 0);
      end
      res_ready = ($urandom_range(99) < rdy_pct);
      drive(1, c, ($urandom_range(99) < abort_pct));
    end
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2);
    rst = 0;
  endtask

  // Returns the number of edges after the last beat before res_valid shows.
  task automatic wait_res(output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
      else lat++;
    end
    if (!seen) chk("res_timeout", 0, 1);
  endtask

  task automatic expect_res(input string name, input int mx, input int my, input int sd);
    chk({name, "_mv_x"}, $signed(res_mv_x), mx);
    chk({name, "_mv_y"}, $signed(res_mv_y), my);
    chk({name, "_sad"}, res_min_sad, sd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1; sad_valid = 0; abort = 0; res_ready = 1; sad_in = '0;
    sad_valid2 = 0; abort2 = 0; res_ready2 = 1; sad_in2 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;

    // Single minimum at col 5 lane 3.
    fill(1000); stim[5][3] = 12;
    send_block(0, 0, 100);
    wait_res(lat);
    chk("single_latency", lat, 4);
    expect_res("single", -3, -5, 12);
    @(negedge clk);
    chk("single_pulse_end", res_valid, 0);
    @(posedge clk); #1;

    // Same block with random gaps.
    send_block(40, 0, 100);
    wait_res(lat);
    expect_res("gaps", -3, -5, 12);
    @(posedge clk); #1;

    // Ties and the all-ones SAD.
    fill(50);
    send_block(0, 0, 100);
    wait_res(lat);
    expect_res("tie50", -8, 7, 50);
    @(posedge clk); #1;
    fill(16383);
    send_block(0, 0, 100);
    wait_res(lat);
    expect_res("allones", -8, 7, 16383);
    @(posedge clk); #1;

    // Back-to-back blocks: two pulses one block apart.
    idle(4);
    pulses.delete();
    fill(900); stim[2][9] = 5;
    send_block(0, 0, 100);
    send_block(0, 0, 100);
    idle(L + 3);
    chk("b2b_count", pulses.size(), 2);
    if (pulses.size() >= 2) chk("b2b_gap", pulses[1] - pulses[0], 16);

    // Back-pressure: second result lost, first held.
    fill(800); stim[2][10] = 1;
    send_block(0, 0, 0);
    fill(800); stim[12][0] = 0;
    send_block(0, 0, 0);
    idle(L + 2);
    chk("bp_overflow", overflow, 1);
    chk("bp_valid", res_valid, 1);
    expect_res("bp_held", -6, 2, 1);
    res_ready = 1;
    idle(1);
    @(negedge clk);
    chk("bp_drained", res_valid, 0);
    chk("bp_overflow_sticky", overflow, 1);
    @(posedge clk); #1;
    do_reset();

    // abort with the col 9 beat, then a fresh block.
    fill(200);
    for (int c = 0; c < 9; c++) drive(1, c, 0);
    drive(1, 9, 1);
    chk("abort_busy_clear", busy, 0);
    fill(100); stim[0][0] = 7;
    send_block(0, 0, 100);
    wait_res(lat);
    expect_res("abort", -8, -8, 7);
    @(posedge clk); #1;

    // Reset mid-block.
    fill(300); stim[7][15] = 4;
    for (int c = 0; c < 6; c++) drive(1, c, 0);
    do_reset();
    send_block(0, 0, 100);
    wait_res(lat);
    expect_res("rst_mid", -1, 7, 4);
    @(posedge clk); #1;

    // Randomised blocks with gaps, aborts and back-pressure.
    for (int b = 0; b < 40; b++) begin
      int mode;
      mode = $urandom_range(2);
      for (int c = 0; c < NC; c++)
        for (int r = 0; r < NR; r++)
          stim[c][r] = (mode == 0) ? SAD_W'($urandom_range(16383)) :
                       (mode == 1) ? SAD_W'($urandom_range(3)) :
                                     SAD_W'($urandom_range(16383, 16380));
      send_block(25, 2, 70);
    end
    res_ready = 1;
    idle(12);

    // Non-default geometry: 8 rows x 32 columns, three tree levels.
    for (int c = 0; c < NC2; c++) begin
      sad_valid2 = 1;
      for (int r = 0; r < NR2; r++)
        sad_in2[r*SAD_W +: SAD_W] = (c == NC2-1 && r == 0) ? SAD_W'(3) : SAD_W'(500);
      @(posedge clk); #1;
    end
    sad_valid2 = 0;
    begin
      bit seen;
      seen = 0; lat = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (res_valid2) seen = 1;
        else lat++;
      end
      chk("p2_seen", seen, 1);
    end
    chk("p2_latency", lat, 3);
    chk("p2_mv_x", $signed(res_mv_x2), 15);
    chk("p2_mv_y", $signed(res_mv_y2), -4);
    chk("p2_sad", res_min_sad2, 3);
    chk("p2_overflow", overflow2, 0);
    @(negedge clk);
    chk("p2_busy", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
